lathe_panel_conditioner: RTL and testbench
==========================================

LATHE_PANEL_CONDITIONER -- requirements
Module: lathe_panel_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 16: consecutive stable synchronized cycles required to accept a level change; legal range 1..2^CNT_W-1.
REQ-002 Parameter CNT_W, default 8: debounce counter width per channel.
REQ-003 clk  input  1  single system clock; all flops on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ena  input  1  block enable; low freezes counters, stable levels and mode, and forces pulses to 0.
REQ-006 start_raw  input  1  raw START pushbutton, active-high.
REQ-007 stop_raw  input  1  raw STOP pushbutton, active-high.
REQ-008 auto_raw  input  1  raw AUTO selector contact, active-high.
REQ-009 man_raw  input  1  raw MAN selector contact, active-high.
REQ-010 start_pulse  output  1  one-cycle qualified START request to the downstream latch/timer stage.
REQ-011 stop_pulse  output  1  one-cycle STOP request, including forced stops.
REQ-012 mode_auto  output  1  validated AUTO mode.
REQ-013 mode_man  output  1  validated MAN mode.
REQ-014 mode_fault  output  1  AUTO and MAN both asserted; sticky until both released.
REQ-015 stable_vec  output  4  debounced levels {man, auto, stop, start}, bit 0 = start.

Function
REQ-016 Each raw input passes through an N-flop synchronizer, N = 2 by default (see REQ-033).
REQ-017 Per channel: counter clears whenever the synchronized value equals the stable bit; otherwise it increments; when it reaches DB_CYCLES the stable bit takes the synchronized value and the counter clears in the same edge.
REQ-018 Any glitch shorter than DB_CYCLES cycles after synchronization leaves the stable bit unchanged; the counter never wraps.
REQ-019 Latency: a clean raw level change is reflected on stable_vec exactly N + DB_CYCLES rising edges later; pulses follow one edge after that.
REQ-020 Mode FSM states: IDLE, AUTO, MAN, FAULT; encoded outputs IDLE=000, AUTO=100, MAN=010, FAULT=001 on {mode_auto, mode_man, mode_fault}.
REQ-021 Transitions, evaluated on stable auto/man each cycle: both high -> FAULT from any state; auto only -> AUTO; man only -> MAN; neither -> IDLE; FAULT exits only to IDLE when both low.
REQ-022 Any FSM transition out of AUTO or MAN asserts stop_pulse for one cycle (forced stop on mode change or loss).
REQ-023 start_pulse asserts for one cycle on a stable rising edge of start only when FSM is AUTO or MAN and stable stop is low.
REQ-024 stop_pulse asserts for one cycle on a stable rising edge of stop, regardless of mode.
REQ-025 Simultaneous start and stop rising edges in the same cycle: stop_pulse only; start_pulse suppressed.
REQ-026 Start edge coincident with a mode transition: start_pulse suppressed; forced stop_pulse issued.
REQ-027 Holding start high produces exactly one start_pulse; a new pulse requires release (stable low) and re-press.
REQ-028 ena low: no counter or state updates; edges occurring while disabled are not reported after re-enable.

Reset
REQ-029 rst_n low asynchronously clears all synchronizer flops, counters, stable_vec and pulse registers to 0.
REQ-030 Reset values: start_pulse=0, stop_pulse=0, mode_auto=0, mode_man=0, mode_fault=0, stable_vec=0000, FSM=IDLE.
REQ-031 Reset mid-debounce discards partial counts; inputs held high through reset are accepted DB_CYCLES + N cycles after release, a held start yielding one start_pulse only if mode is valid by then.
REQ-032 Reset release is not itself a mode transition; no forced stop_pulse from IDLE.

Configuration
REQ-033 Macro PANEL_SYNC3_EN: defined -> N = 3 synchronizer flops per input and REQ-019 latency becomes 3 + DB_CYCLES; undefined -> N = 2; no other behaviour changes.

Verification (DB_CYCLES=4, macro undefined unless stated)
REQ-034 Reset, auto_raw=1 held 10 cycles -> mode_auto=1 at edge 6 after release of raw change, mode_fault=0, no pulses.
REQ-035 AUTO valid, start_raw high 20 cycles -> exactly one start_pulse, 7 edges after raw rise; 3-cycle start glitch -> no pulse.
REQ-036 AUTO valid, start_raw and stop_raw rise same cycle -> stop_pulse=1 once, start_pulse never.
REQ-037 AUTO valid, then man_raw=1 (both high) -> FAULT (001) plus one stop_pulse; release auto only -> stays FAULT; release both -> IDLE, then man -> MAN.
REQ-038 Start press with no mode selected -> no start_pulse; rst_n pulsed low mid-debounce -> all outputs 0 immediately.
REQ-039 PANEL_SYNC3_EN defined, repeat REQ-035 -> pulse 8 edges after raw rise.

Source files
------------

// File: rtl/lathe_panel_conditioner.sv
// rtl/lathe_panel_conditioner.sv - lathe operator panel input conditioner (sync, debounce, mode FSM, pulses); PANEL_SYNC3_EN selects 3-flop synchronizers
module lathe_panel_conditioner #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start_raw,
    input  logic       stop_raw,
    input  logic       auto_raw,
    input  logic       man_raw,
    output logic       start_pulse,
    output logic       stop_pulse,
    output logic       mode_auto,
    output logic       mode_man,
    output logic       mode_fault,
    output logic [3:0] stable_vec
);

`ifdef PANEL_SYNC3_EN
    localparam int SYNC_N = 3;
`else
    localparam int SYNC_N = 2;
`endif

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_AUTO  = 2'd1;
    localparam logic [1:0] ST_MAN   = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]                    raw_vec;
    logic [SYNC_N-1:0][3:0]        sync_q;
    logic [3:0]                    sync_out;
    logic [3:0][CNT_W-1:0]         cnt_q;
    logic [3:0][CNT_W-1:0]         cnt_d;
    logic [3:0]                    stable_q;
    logic [3:0]                    stable_d;
    logic [1:0]                    stable_prev_q;
    logic [1:0]                    state_q;
    logic [1:0]                    state_d;
    logic [1:0]                    state_prev_q;
    logic                          start_rise;
    logic                          stop_rise;
    logic                          mode_change;
    logic                          forced_stop;
    logic                          mode_valid;
    logic                          start_ok;
    logic                          start_pulse_q;
    logic                          stop_pulse_q;

    assign raw_vec  = {man_raw, auto_raw, stop_raw, start_raw};
    assign sync_out = sync_q[SYNC_N-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], raw_vec};
        end
    end

    // Counter only runs while the synchronized level disagrees with the accepted one.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            if (sync_out[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]    = '0;
                stable_d[i] = sync_out[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Mode follows the levels accepted on this edge so it lines up with stable_vec.
    always_comb begin
        state_d = ST_IDLE;
        if (stable_d[2] && stable_d[3]) begin
            state_d = ST_FAULT;
        end else if (state_q == ST_FAULT && (stable_d[2] || stable_d[3])) begin
            state_d = ST_FAULT;
        end else if (stable_d[2]) begin
            state_d = ST_AUTO;
        end else if (stable_d[3]) begin
            state_d = ST_MAN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= '0;
            state_q  <= ST_IDLE;
        end else if (ena) begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            state_q  <= state_d;
        end
    end

    // History tracks even while disabled so edges seen during ena low are consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_prev_q <= '0;
            state_prev_q  <= ST_IDLE;
        end else begin
            stable_prev_q <= stable_q[1:0];
            state_prev_q  <= state_q;
        end
    end

    assign start_rise  = stable_q[0] & ~stable_prev_q[0];
    assign stop_rise   = stable_q[1] & ~stable_prev_q[1];
    assign mode_change = (state_q != state_prev_q);
    assign forced_stop = mode_change && (state_prev_q == ST_AUTO || state_prev_q == ST_MAN);
    assign mode_valid  = (state_q == ST_AUTO) || (state_q == ST_MAN);
    assign start_ok    = start_rise && mode_valid && !stable_q[1] && !mode_change;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_pulse_q <= 1'b0;
            stop_pulse_q  <= 1'b0;
        end else begin
            start_pulse_q <= ena && start_ok;
            stop_pulse_q  <= ena && (stop_rise || forced_stop);
        end
    end

    assign start_pulse = start_pulse_q;
    assign stop_pulse  = stop_pulse_q;
    assign mode_auto   = (state_q == ST_AUTO);
    assign mode_man    = (state_q == ST_MAN);
    assign mode_fault  = (state_q == ST_FAULT);
    assign stable_vec  = stable_q;

endmodule

// File: tb/tb_lathe_panel_conditioner.sv
// tb/tb_lathe_panel_conditioner.sv - self-checking bench for lathe_panel_conditioner against a behavioural panel model
module tb_lathe_panel_conditioner;

    localparam int DB = 4;
`ifdef PANEL_SYNC3_EN
    localparam int N_SYNC = 3;
`else
    localparam int N_SYNC = 2;
`endif

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       start_raw;
    logic       stop_raw;
    logic       auto_raw;
    logic       man_raw;
    logic       start_pulse;
    logic       stop_pulse;
    logic       mode_auto;
    logic       mode_man;
    logic       mode_fault;
    logic [3:0] stable_vec;

    int n_tests;
    int n_fail;

    lathe_panel_conditioner #(.DB_CYCLES(DB), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start_raw  (start_raw),
        .stop_raw   (stop_raw),
        .auto_raw   (auto_raw),
        .man_raw    (man_raw),
        .start_pulse(start_pulse),
        .stop_pulse (stop_pulse),
        .mode_auto  (mode_auto),
        .mode_man   (mode_man),
        .mode_fault (mode_fault),
        .stable_vec (stable_vec)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: raw levels reach the debouncer N_SYNC edges late; a level is accepted
    // after DB consecutive disagreeing cycles; mode 0=idle 1=auto 2=man 3=fault.
    logic [3:0] m_pipe[$];
    int         m_run[4];
    logic [3:0] m_stable;
    logic [3:0] m_stable_prev;
    int         m_mode;
    int         m_mode_prev;
    logic       m_start;
    logic       m_stop;

    int n_start;
    int n_stop;
    int first_start;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] mode_bits(input int m);
        case (m)
            1:       return 3'b100;
            2:       return 3'b010;
            3:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit is_run_mode(input int m);
        return (m == 1) || (m == 2);
    endfunction

    task automatic model_reset();
        m_pipe = {};
        repeat (N_SYNC) m_pipe.push_back(4'b0);
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_stable      = '0;
        m_stable_prev = '0;
        m_mode        = 0;
        m_mode_prev   = 0;
        m_start       = 1'b0;
        m_stop        = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] synced;
        logic       a;
        logic       m;
        bit         changed;
        if (!rst_n) begin
            model_reset();
            return;
        end
        synced = m_pipe.pop_front();
        m_pipe.push_back({man_raw, auto_raw, stop_raw, start_raw});
        changed = (m_mode != m_mode_prev);
        if (ena) begin
            m_stop  = (m_stable[1] && !m_stable_prev[1]) || (changed && is_run_mode(m_mode_prev));
            m_start = m_stable[0] && !m_stable_prev[0] && is_run_mode(m_mode) && !m_stable[1] && !changed;
        end else begin
            m_stop  = 1'b0;
            m_start = 1'b0;
        end
        m_stable_prev = m_stable;
        m_mode_prev   = m_mode;
        if (ena) begin
            for (int i = 0; i < 4; i++) begin
                m_run[i] = (synced[i] == m_stable[i]) ? 0 : m_run[i] + 1;
                if (m_run[i] == DB) begin
                    m_stable[i] = synced[i];
                    m_run[i]    = 0;
                end
            end
            a = m_stable[2];
            m = m_stable[3];
            if (a && m)                   m_mode = 3;
            else if (m_mode == 3 && (a || m)) m_mode = 3;
            else if (a)                   m_mode = 1;
            else if (m)                   m_mode = 2;
            else                          m_mode = 0;
        end
    endtask

    task automatic compare_all();
        check("stable_vec", stable_vec, m_stable);
        check("mode", {mode_auto, mode_man, mode_fault}, mode_bits(m_mode));
        check("start_pulse", start_pulse, m_start);
        check("stop_pulse", stop_pulse, m_stop);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        n_start     = 0;
        n_stop      = 0;
        first_start = -1;
        for (int k = 1; k <= n; k++) begin
            step();
            if (start_pulse) begin
                n_start++;
                if (first_start < 0) first_start = k;
            end
            if (stop_pulse) n_stop++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_async_outputs", {start_pulse, stop_pulse, mode_auto, mode_man, mode_fault, stable_vec}, 9'b0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        ena       = 1'b1;
        start_raw = 1'b0;
        stop_raw  = 1'b0;
        auto_raw  = 1'b0;
        man_raw   = 1'b0;
        model_reset();
        #2;
        check("reset_state", {start_pulse, stop_pulse, mode_auto, mode_man, mode_fault, stable_vec}, 9'b0);
        do_reset();

        // AUTO selected: mode appears exactly N_SYNC + DB edges after the raw change
        auto_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == N_SYNC + DB - 1) check("auto_before_latency", mode_auto, 1'b0);
            if (k == N_SYNC + DB)     check("auto_at_latency", mode_auto, 1'b1);
            if (start_pulse || stop_pulse) check("auto_no_pulse", {start_pulse, stop_pulse}, 2'b00);
        end
        check("auto_no_fault", mode_fault, 1'b0);

        // Held start gives exactly one pulse, one edge after acceptance
        start_raw = 1'b1;
        run(20);
        check("start_held_count", n_start, 1);
        check("start_latency", first_start, N_SYNC + DB + 1);
        start_raw = 1'b0;
        run(12);
        start_raw = 1'b1;
        run(3);
        start_raw = 1'b0;
        run(15);
        check("start_glitch_count", n_start, 0);

        // Simultaneous start and stop presses
        start_raw = 1'b1;
        stop_raw  = 1'b1;
        run(12);
        check("sim_stop_count", n_stop, 1);
        check("sim_start_count", n_start, 0);
        start_raw = 1'b0;
        stop_raw  = 1'b0;
        run(12);

        // AUTO + MAN -> FAULT with forced stop; sticky until both released
        man_raw = 1'b1;
        run(12);
        check("fault_mode", {mode_auto, mode_man, mode_fault}, 3'b001);
        check("fault_forced_stop", n_stop, 1);
        auto_raw = 1'b0;
        run(12);
        check("fault_sticky", {mode_auto, mode_man, mode_fault}, 3'b001);
        man_raw = 1'b0;
        run(12);
        check("fault_exit_idle", {mode_auto, mode_man, mode_fault}, 3'b000);
        check("fault_exit_no_stop", n_stop, 0);
        man_raw = 1'b1;
        run(12);
        check("man_mode", {mode_auto, mode_man, mode_fault}, 3'b010);
        man_raw = 1'b0;
        run(12);

        // Start with no mode selected is ignored
        start_raw = 1'b1;
        run(12);
        check("idle_start_count", n_start, 0);
        start_raw = 1'b0;
        run(12);

        // Reset in the middle of a debounce window
        man_raw = 1'b1;
        run(N_SYNC + 2);
        do_reset();
        run(N_SYNC + DB + 2);
        check("post_reset_man", mode_man, 1'b1);

        // Randomized panel activity with occasional disable and reset
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) start_raw = ~start_raw;
            if ($urandom_range(0, 9) == 0) stop_raw  = ~stop_raw;
            if ($urandom_range(0, 23) == 0) auto_raw = ~auto_raw;
            if ($urandom_range(0, 23) == 0) man_raw  = ~man_raw;
            ena = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
